// File: rtl/paralelo_serial_phy_tx_pkg.sv
// rtl/paralelo_serial_phy_tx_pkg.sv - shared PHY constants and state encoding
// Purpose: alignment byte, default sync length and link state encoding,
//          shared by the TX serializer and the matching RX deserializer.
package paralelo_serial_phy_tx_pkg;

  localparam logic [7:0] PHY_COMMA       = 8'hBC;
  localparam int         PHY_SYNC_COMMAS = 4;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } phy_state_e;

endpackage

// File: rtl/paralelo_serial_phy_tx_if.sv
// rtl/paralelo_serial_phy_tx_if.sv - byte-in / bit-out link interface
// Purpose: groups the parallel byte handshake and the serial/status outputs.
// Signals:
//   data_in  [7:0] byte to transmit         (master -> slave)
//   valid_in       data_in is valid         (master -> slave)
//   ready          byte accepted when valid (slave -> master)
//   data_out       serial stream, MSB first (slave -> master)
//   active         sync complete            (slave -> master)
interface paralelo_serial_phy_tx_if;

  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;
  logic       data_out;
  logic       active;

  modport master (
    output data_in,
    output valid_in,
    input  ready,
    input  data_out,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready,
    output data_out,
    output active
  );

endinterface

// File: rtl/paralelo_serial_phy_tx_shifter.sv
// rtl/paralelo_serial_phy_tx_shifter.sv - 8-bit load/shift serializer
// Purpose: shifts a byte out MSB first; a load replaces the shift in that cycle.
// Ports:
//   clk_32f      bit clock
//   reset_L      asynchronous active-low reset (register returns to COMMA)
//   load_i       load load_data_i instead of shifting
//   load_data_i  byte to load
//   data_o       serial output, always the register MSB
module phy_tx_shifter #(
  parameter logic [7:0] COMMA = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  output logic       data_o
);

  logic [7:0] sreg_q;
  logic [7:0] sreg_d;

  always_comb begin
    sreg_d = {sreg_q[6:0], 1'b0};
    if (load_i) begin
      sreg_d = load_data_i;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sreg_q <= COMMA;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign data_o = sreg_q[7];

endmodule

// File: rtl/paralelo_serial_phy_tx.sv
// rtl/paralelo_serial_phy_tx.sv - parallel-to-serial PHY transmitter
// Purpose: sends SYNC_COMMAS+1 alignment commas after reset, then serializes
//          accepted bytes back-to-back, filling empty byte slots with COMMA.
// Ports:
//   clk_32f   bit clock, all state on its rising edge
//   reset_L   asynchronous active-low reset
//   phy       slave side of the link interface (data_in, valid_in, ready,
//             data_out, active)
module paralelo_serial_phy_tx
  import paralelo_serial_phy_tx_pkg::*;
#(
  parameter logic [7:0] COMMA       = PHY_COMMA,
  parameter int         SYNC_COMMAS = PHY_SYNC_COMMAS
) (
  input  logic                     clk_32f,
  input  logic                     reset_L,
  paralelo_serial_phy_tx_if.slave  phy
);

  localparam int SYNC_W = $clog2(SYNC_COMMAS + 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COMMAS - 1);

  phy_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_full_q, hold_full_d;

  logic       boundary;
  logic       accept;
  logic       load_hold;
  logic       ready_int;
  logic       active_int;
  logic [7:0] load_byte;

  // Last bit of the current byte: the shifter loads the next byte on this edge.
  assign boundary  = (bit_cnt_q == 3'd7);
  assign accept    = phy.valid_in && ready_int;
  // state_q is still SYNC at the SYNC->ACTIVE boundary, so that slot gets a comma.
  assign load_hold = boundary && (state_q == ST_ACTIVE) && hold_full_q;
  assign load_byte = load_hold ? hold_q : COMMA;

  // State register
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ACTIVE is left only through reset
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_SYNC) && boundary && (sync_cnt_q == SYNC_LAST)) begin
      state_d = ST_ACTIVE;
    end
  end

  // Outputs depend only on registers, never on valid_in
  always_comb begin
    active_int = (state_q == ST_ACTIVE);
    ready_int  = (state_q == ST_ACTIVE) && !hold_full_q;
  end

  // Datapath next-state
  always_comb begin
    bit_cnt_d   = bit_cnt_q + 3'd1;
    sync_cnt_d  = sync_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if ((state_q == ST_SYNC) && boundary && (sync_cnt_q != SYNC_LAST)) begin
      sync_cnt_d = sync_cnt_q + 1'b1;
    end

    if (load_hold) begin
      hold_full_d = 1'b0;
    end

    // An accept needs an empty hold, so it never collides with load_hold;
    // a byte accepted on a boundary waits for the following slot.
    if (accept) begin
      hold_d      = phy.data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q   <= 3'd0;
      sync_cnt_q  <= '0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  phy_tx_shifter #(
    .COMMA (COMMA)
  ) u_shifter (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .load_i      (boundary),
    .load_data_i (load_byte),
    .data_o      (phy.data_out)
  );

  assign phy.ready  = ready_int;
  assign phy.active = active_int;

endmodule
